// File: rtl/ita_gelu_requant.sv
// Requantizes wide signed GELU results: multiply, round-half-up shift, offset, saturate to OUT_WIDTH.
// Latency: 3 register stages (multiply, round/shift, offset/saturate); 1 beat/cycle throughput.
// Backpressure: stages compact on stall; ready_o is combinational from ready_i and drops only when all stages are full.
module ita_gelu_requant #(
   parameter int unsigned IN_WIDTH    = 32,
   parameter int unsigned OUT_WIDTH   = 8,
   parameter int unsigned MULT_WIDTH  = 8,
   parameter int unsigned SHIFT_WIDTH = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [IN_WIDTH-1:0]    data_i,
   input  logic [MULT_WIDTH-1:0]  mult_i,
   input  logic [SHIFT_WIDTH-1:0] shift_i,
   input  logic [OUT_WIDTH-1:0]   add_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [OUT_WIDTH-1:0]   data_o
);

   // Product width holds the full signed x unsigned result; RW adds a guard bit
   // so the rounding add cannot overflow; SW adds one more for the offset add.
   localparam int unsigned PW = IN_WIDTH + MULT_WIDTH + 1;
   localparam int unsigned RW = PW + 1;
   localparam int unsigned SW = RW + 1;

   localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [SHIFT_WIDTH-1:0] SHIFT_ONE = {{(SHIFT_WIDTH-1){1'b0}}, 1'b1};

   // Stage valid bits
   logic s1_vld_q, s1_vld_d;
   logic s2_vld_q, s2_vld_d;
   logic s3_vld_q, s3_vld_d;

   // Stage payloads; configuration travels with its own beat
   logic signed [PW-1:0]    s1_p_q, s1_p_d;
   logic [SHIFT_WIDTH-1:0]  s1_shift_q, s1_shift_d;
   logic [OUT_WIDTH-1:0]    s1_add_q, s1_add_d;
   logic signed [RW-1:0]    s2_r_q, s2_r_d;
   logic [OUT_WIDTH-1:0]    s2_add_q, s2_add_d;
   logic [OUT_WIDTH-1:0]    s3_dat_q, s3_dat_d;

   // Per-stage update enables
   logic s1_en, s2_en, s3_en;
   logic in_hs;

   // Datapath intermediates
   logic signed [PW-1:0] mul_a, mul_b;
   logic signed [RW-1:0] p_ext, rnd, rsum;
   logic        [SW-1:0] ssum;
   logic [SW-OUT_WIDTH:0] ssum_hi;

   // A stage may update when it is empty or its content moves on this edge
   always_comb begin
      s3_en   = !s3_vld_q || ready_i;
      s2_en   = !s2_vld_q || s3_en;
      s1_en   = !s1_vld_q || s2_en;
      ready_o = s1_en && !clear_i;
      in_hs   = valid_i && ready_o;
   end

   // Next-state of the valid chain; clear drops every beat in flight
   always_comb begin
      s1_vld_d = s1_vld_q;
      s2_vld_d = s2_vld_q;
      s3_vld_d = s3_vld_q;
      if (s1_en) s1_vld_d = in_hs;
      if (s2_en) s2_vld_d = s1_vld_q;
      if (s3_en) s3_vld_d = s2_vld_q;
      if (clear_i) begin
         s1_vld_d = 1'b0;
         s2_vld_d = 1'b0;
         s3_vld_d = 1'b0;
      end
   end

   // S1: signed data times zero-extended multiplier, full width
   always_comb begin
      mul_a      = {{(PW-IN_WIDTH){data_i[IN_WIDTH-1]}}, data_i};
      mul_b      = {{(PW-MULT_WIDTH){1'b0}}, mult_i};
      s1_p_d     = mul_a * mul_b;
      s1_shift_d = shift_i;
      s1_add_d   = add_i;
   end

   // S2: add half an LSB of the shifted result, then arithmetic shift (round half toward +inf)
   always_comb begin
      p_ext = {s1_p_q[PW-1], s1_p_q};
      rnd   = '0;
      rsum  = p_ext;
      s2_r_d = p_ext;
      if (s1_shift_q != '0) begin
         rnd    = {{(RW-1){1'b0}}, 1'b1} << (s1_shift_q - SHIFT_ONE);
         rsum   = p_ext + rnd;
         s2_r_d = rsum >>> s1_shift_q;
      end
      s2_add_d = s1_add_q;
   end

   // S3: sign-extended offset, then clip when the upper bits are not a pure sign extension
   always_comb begin
      ssum    = {s2_r_q[RW-1], s2_r_q} + {{(SW-OUT_WIDTH){s2_add_q[OUT_WIDTH-1]}}, s2_add_q};
      ssum_hi = ssum[SW-1:OUT_WIDTH-1];
      s3_dat_d = ssum[OUT_WIDTH-1:0];
      if (ssum[SW-1] && !(&ssum_hi)) begin
         s3_dat_d = SAT_MIN;
      end else if (!ssum[SW-1] && (|ssum_hi)) begin
         s3_dat_d = SAT_MAX;
      end
   end

   // Pipeline registers; payloads only load with a valid beat so a stalled output holds
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_vld_q   <= 1'b0;
         s2_vld_q   <= 1'b0;
         s3_vld_q   <= 1'b0;
         s1_p_q     <= '0;
         s1_shift_q <= '0;
         s1_add_q   <= '0;
         s2_r_q     <= '0;
         s2_add_q   <= '0;
         s3_dat_q   <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
         s3_vld_q <= s3_vld_d;
         if (s1_en && in_hs) begin
            s1_p_q     <= s1_p_d;
            s1_shift_q <= s1_shift_d;
            s1_add_q   <= s1_add_d;
         end
         if (s2_en && s1_vld_q) begin
            s2_r_q   <= s2_r_d;
            s2_add_q <= s2_add_d;
         end
         if (s3_en && s2_vld_q) begin
            s3_dat_q <= s3_dat_d;
         end
      end
   end

   assign valid_o = s3_vld_q;
   assign data_o  = s3_dat_q;

endmodule

// File: tb/tb_ita_gelu_requant.sv
// Scoreboard bench for ita_gelu_requant: reference results queued at input handshake, compared at output handshake.
// Drives inputs #1 after the rising edge, samples on the falling edge.
// Checks ready_o every cycle against the in-flight count and output hold during stalls.
module tb_ita_gelu_requant;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clear_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_i;
   logic [7:0]  mult_i;
   logic [4:0]  shift_i;
   logic [7:0]  add_i;
   logic        valid_o;
   logic        ready_i;
   logic [7:0]  data_o;

   always #5 clk_i = ~clk_i;

   ita_gelu_requant dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .mult_i  (mult_i),
      .shift_i (shift_i),
      .add_i   (add_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o)
   );

   int     n_chk  = 0;
   int     n_pass = 0;
   longint sb[$];
   int     cyc_cnt  = 0;
   int     n_out    = 0;
   int     first_vo = -1;
   int     vo_cnt   = 0;
   bit     hold_prev = 1'b0;
   logic [7:0] held_dat = '0;
   bit     last_vo;
   logic [7:0] last_do;

   task automatic check(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   function automatic longint model(input longint d, input longint m, input int s, input longint a);
      longint p, r, t;
      p = d * m;
      if (s == 0) r = p;
      else        r = (p + (longint'(1) <<< (s - 1))) >>> s;
      t = r + a;
      if (t > 127)  t = 127;
      if (t < -128) t = -128;
      return t;
   endfunction

   // One clock cycle: drive, sample/check at negedge, update scoreboard after the edge
   task automatic cyc(input bit v, input int d, input int m, input int s, input int a,
                      input bit rdy, input bit clr, input bit rst, output bit acc);
      bit out_hs;
      bit exp_rdy;
      valid_i = v;
      data_i  = d;
      mult_i  = m[7:0];
      shift_i = s[4:0];
      add_i   = a[7:0];
      ready_i = rdy;
      clear_i = clr;
      rst_ni  = rst;
      @(negedge clk_i);
      acc     = valid_i && ready_o && rst_ni;
      out_hs  = valid_o && ready_i && rst_ni;
      last_vo = valid_o;
      last_do = data_o;
      if (rst_ni) begin
         exp_rdy = !clear_i && !(sb.size() == 3 && !ready_i);
         check("ready_o", longint'(ready_o), longint'(exp_rdy));
         if (hold_prev) begin
            check("hold_vld", longint'(valid_o), 1);
            check("hold_dat", longint'($signed(data_o)), longint'($signed(held_dat)));
         end
         if (valid_o && sb.size() == 0) check("spurious_vld", longint'(valid_o), 0);
      end
      if (valid_o && first_vo < 0) first_vo = cyc_cnt;
      if (valid_o) vo_cnt++;
      if (out_hs && sb.size() > 0) begin
         check("data_o", longint'($signed(data_o)), sb.pop_front());
         n_out++;
      end
      hold_prev = valid_o && !ready_i && rst_ni && !clear_i;
      held_dat  = data_o;
      @(posedge clk_i);
      #1;
      cyc_cnt++;
      if (!rst || clr) sb.delete();
      else if (acc) sb.push_back(model(longint'(d), longint'(m), s, longint'(a)));
   endtask

   initial begin
      bit acc;
      bit rdy;
      int t0;
      int base;
      int idx;

      // Reset
      cyc(0, 0, 0, 0, 0, 1, 0, 0, acc);
      cyc(0, 0, 0, 0, 0, 1, 0, 0, acc);
      cyc(0, 0, 0, 0, 0, 1, 0, 1, acc);
      check("rst_vld", longint'(last_vo), 0);
      check("rst_dat", longint'($signed(last_do)), 0);

      // Basic beat: latency and single-cycle valid pulse
      first_vo = -1;
      vo_cnt   = 0;
      t0       = cyc_cnt;
      cyc(1, 100, 3, 2, -10, 1, 0, 1, acc);
      check("basic_acc", longint'(acc), 1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1, acc);
      check("latency", longint'(first_vo - t0), 3);
      check("vo_pulse", longint'(vo_cnt), 1);
      check("basic_expect", model(100, 3, 2, -10), 65);

      // Rounding, shift bypass, saturation, per-beat configuration: back-to-back
      base = n_out;
      cyc(1, -50, 5, 3, 0, 1, 0, 1, acc);
      cyc(1, 7, 1, 0, 0, 1, 0, 1, acc);
      cyc(1, 1000, 64, 8, 0, 1, 0, 1, acc);
      cyc(1, -1000, 64, 8, 0, 1, 0, 1, acc);
      cyc(1, 10, 1, 0, 0, 1, 0, 1, acc);
      cyc(1, 10, 1, 1, 0, 1, 0, 1, acc);
      cyc(1, -3, 1, 1, 0, 1, 0, 1, acc);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1, acc);
      check("stream_count", longint'(n_out - base), 7);

      // Back-pressure: beats 1..8 with random ready and a 6-cycle stall
      base = n_out;
      idx  = 1;
      for (int c = 0; c < 300 && n_out < base + 8; c++) begin
         rdy = (c >= 3 && c < 9) ? 1'b0 : 1'($urandom_range(0, 1));
         cyc(idx <= 8, idx, 1, 0, 0, rdy, 0, 1, acc);
         if (acc) idx++;
      end
      check("bp_count", longint'(n_out - base), 8);
      check("bp_sent", longint'(idx - 1), 8);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1, acc);

      // Flush with clear_i on a full stalled pipeline
      for (int i = 0; i < 3; i++) cyc(1, 20 + i, 1, 0, 0, 0, 0, 1, acc);
      cyc(0, 0, 0, 0, 0, 0, 1, 1, acc);
      cyc(0, 0, 0, 0, 0, 1, 0, 1, acc);
      check("clr_vld", longint'(last_vo), 0);
      base = n_out;
      cyc(1, 42, 1, 0, 5, 1, 0, 1, acc);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1, acc);
      check("clr_count", longint'(n_out - base), 1);

      // Same with reset instead of clear
      for (int i = 0; i < 3; i++) cyc(1, -20 - i, 1, 0, 0, 0, 0, 1, acc);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, acc);
      cyc(0, 0, 0, 0, 0, 1, 0, 1, acc);
      check("rst2_vld", longint'(last_vo), 0);
      check("rst2_dat", longint'($signed(last_do)), 0);
      base = n_out;
      cyc(1, -9, 3, 1, 0, 1, 0, 1, acc);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1, acc);
      check("rst2_count", longint'(n_out - base), 1);
      check("sb_empty", longint'(sb.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
